// File: rtl/dual_port_bank_mem.sv
// dual_port_bank_mem
// ------------------
// Dual-port, byte-banked on-chip memory for the RV MCU. The instruction port
// is read-only and serves the fetch stage; the data port serves loads and
// stores from the execute stage. Both ports operate every cycle.
//
// Optional feature macro: MEM_OUT_REG_EN
//   - defined   : an extra output register on both ports, giving 2-cycle latency
//   - undefined : 1-cycle latency (default)
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous active-low reset (memory contents are kept)
//   if_req_i     fetch request
//   if_addr_i    fetch byte address
//   if_rdata_o   fetched word; INSTR_NOP when no fetch response is present
//   if_ack_o     fetch response valid (a held request acks every second cycle)
//   if_err_o     fetch address out of range, valid with if_ack_o
//   d_req_i      data request
//   d_sel_i      data-bus decode select for this memory
//   d_we_i       1 = store, 0 = load
//   d_addr_i     data byte address
//   d_wdata_i    store data
//   d_be_i       byte enables, one per bank, any combination
//   d_rdata_o    load data; holds its last value between loads
//   d_ack_o      data response valid
//   d_err_o      data address out of range, valid with d_ack_o

module dual_port_bank_mem #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter int                BYTE_OFS  = $clog2(DATA_W / 8),
    parameter logic [DATA_W-1:0] INSTR_NOP = DATA_W'(32'h0000_0013)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_ack_o,
    output logic                  if_err_o,
    input  logic                  d_req_i,
    input  logic                  d_sel_i,
    input  logic                  d_we_i,
    input  logic [31:0]           d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_ack_o,
    output logic                  d_err_o
);

    localparam int          NB      = DATA_W / 8;
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] LO_MASK = (32'd1 << BYTE_OFS) - 32'd1;

    // An address is out of range when any bit above the word index is set,
    // or when it is not aligned to a full word.
    function automatic logic addrBad(input logic [31:0] addr);
        return ((addr >> (BYTE_OFS + AW)) != 32'd0) || ((addr & LO_MASK) != 32'd0);
    endfunction

    logic [AW-1:0]     ifIdx;
    logic [AW-1:0]     dIdx;
    logic              ifBad;
    logic              dBad;
    logic              dAccess;
    logic              dStore;
    logic [DATA_W-1:0] ifWord;
    logic [DATA_W-1:0] dWord;

    assign ifIdx   = AW'(if_addr_i >> BYTE_OFS);
    assign dIdx    = AW'(d_addr_i >> BYTE_OFS);
    assign ifBad   = addrBad(if_addr_i);
    assign dBad    = addrBad(d_addr_i);
    assign dAccess = d_req_i & d_sel_i;
    assign dStore  = dAccess & d_we_i & ~dBad;

    // One independent byte-wide array per bank. Writes are suppressed while
    // reset is asserted so a store presented in a reset cycle is dropped.
    // Reads are combinational and captured in the port registers below, so a
    // fetch hitting a word being stored in the same cycle sees the old value.
    for (genvar b = 0; b < NB; b++) begin : gBank
        logic [7:0] bankMem [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_ni && dStore && d_be_i[b]) begin
                bankMem[dIdx] <= d_wdata_i[8*b +: 8];
            end
        end

        assign ifWord[8*b +: 8] = bankMem[ifIdx];
        assign dWord[8*b +: 8]  = bankMem[dIdx];
    end

    logic              ifAck_q,   ifAck_d;
    logic              ifErr_q,   ifErr_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic              dAck_q,    dAck_d;
    logic              dErr_q,    dErr_d;
    logic [DATA_W-1:0] dRdata_q,  dRdata_d;
    logic              ifFire;

    // Response next-state. The fetch port only accepts a request when it did
    // not ack in the previous cycle, which yields the alternating ack pattern
    // for a held request. Load data is only updated by loads so it holds
    // across stores and idle cycles.
    always_comb begin
        ifFire    = if_req_i & ~ifAck_q;
        ifAck_d   = ifFire;
        ifErr_d   = ifFire & ifBad;
        ifRdata_d = INSTR_NOP;
        if (ifFire && !ifBad) begin
            ifRdata_d = ifWord;
        end

        dAck_d   = dAccess;
        dErr_d   = dAccess & dBad;
        dRdata_d = dRdata_q;
        if (dAccess && !d_we_i) begin
            dRdata_d = dBad ? '0 : dWord;
        end
    end

    // Stage-1 response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ifAck_q   <= 1'b0;
            ifErr_q   <= 1'b0;
            ifRdata_q <= INSTR_NOP;
            dAck_q    <= 1'b0;
            dErr_q    <= 1'b0;
            dRdata_q  <= '0;
        end else begin
            ifAck_q   <= ifAck_d;
            ifErr_q   <= ifErr_d;
            ifRdata_q <= ifRdata_d;
            dAck_q    <= dAck_d;
            dErr_q    <= dErr_d;
            dRdata_q  <= dRdata_d;
        end
    end

`ifdef MEM_OUT_REG_EN
    logic              ifAckOut_q;
    logic              ifErrOut_q;
    logic [DATA_W-1:0] ifRdataOut_q;
    logic              dAckOut_q;
    logic              dErrOut_q;
    logic [DATA_W-1:0] dRdataOut_q;

    // Second output stage: a plain delay of stage 1. The fetch handshake
    // still runs on the stage-1 ack so the request pattern is unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ifAckOut_q   <= 1'b0;
            ifErrOut_q   <= 1'b0;
            ifRdataOut_q <= INSTR_NOP;
            dAckOut_q    <= 1'b0;
            dErrOut_q    <= 1'b0;
            dRdataOut_q  <= '0;
        end else begin
            ifAckOut_q   <= ifAck_q;
            ifErrOut_q   <= ifErr_q;
            ifRdataOut_q <= ifRdata_q;
            dAckOut_q    <= dAck_q;
            dErrOut_q    <= dErr_q;
            dRdataOut_q  <= dRdata_q;
        end
    end

    assign if_ack_o   = ifAckOut_q;
    assign if_err_o   = ifErrOut_q;
    assign if_rdata_o = ifRdataOut_q;
    assign d_ack_o    = dAckOut_q;
    assign d_err_o    = dErrOut_q;
    assign d_rdata_o  = dRdataOut_q;
`else
    assign if_ack_o   = ifAck_q;
    assign if_err_o   = ifErr_q;
    assign if_rdata_o = ifRdata_q;
    assign d_ack_o    = dAck_q;
    assign d_err_o    = dErr_q;
    assign d_rdata_o  = dRdata_q;
`endif

endmodule

// File: tb/tb_dual_port_bank_mem.sv
// tb_dual_port_bank_mem
// ---------------------
// Directed self-checking bench for dual_port_bank_mem with default
// parameters (32-bit words, 4096 words). Expected values are hand-computed
// constants. Response latency follows MEM_OUT_REG_EN.

module tb_dual_port_bank_mem;

`ifdef MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rstN;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifAck;
    logic        ifErr;
    logic        dReq;
    logic        dSel;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dBe;
    logic [31:0] dRdata;
    logic        dAck;
    logic        dErr;

    int checkCount = 0;
    int failCount  = 0;

    dual_port_bank_mem dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .if_req_i   (ifReq),
        .if_addr_i  (ifAddr),
        .if_rdata_o (ifRdata),
        .if_ack_o   (ifAck),
        .if_err_o   (ifErr),
        .d_req_i    (dReq),
        .d_sel_i    (dSel),
        .d_we_i     (dWe),
        .d_addr_i   (dAddr),
        .d_wdata_i  (dWdata),
        .d_be_i     (dBe),
        .d_rdata_o  (dRdata),
        .d_ack_o    (dAck),
        .d_err_o    (dErr)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog");
    end

    // Every comparison goes through here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data-port transaction; returns the response seen LAT cycles later
    task automatic applyStimulus(input logic we, input logic sel, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] rdata, output logic ack, output logic err);
        dReq   = 1'b1;
        dSel   = sel;
        dWe    = we;
        dAddr  = addr;
        dWdata = wdata;
        dBe    = be;
        tick();
        dReq = 1'b0;
        dSel = 1'b0;
        dWe  = 1'b0;
        repeat (LAT - 1) tick();
        rdata = dRdata;
        ack   = dAck;
        err   = dErr;
    endtask

    // Single fetch from an idle port
    task automatic fetchOnce(input logic [31:0] addr, output logic [31:0] rdata,
                             output logic ack, output logic err);
        ifReq = 1'b0;
        repeat (LAT + 1) tick();
        ifReq  = 1'b1;
        ifAddr = addr;
        tick();
        ifReq = 1'b0;
        repeat (LAT - 1) tick();
        rdata = ifRdata;
        ack   = ifAck;
        err   = ifErr;
    endtask

    logic [31:0] rd;
    logic        ack;
    logic        err;

    initial begin
        rstN   = 1'b0;
        ifReq  = 1'b1;
        ifAddr = 32'h0;
        dReq   = 1'b0;
        dSel   = 1'b0;
        dWe    = 1'b0;
        dAddr  = 32'h0;
        dWdata = 32'h0;
        dBe    = 4'h0;

        // Reset held for 3 cycles with a fetch pending
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_if_ack", {31'd0, ifAck}, 32'd0);
            checkOutput("reset_if_rdata", ifRdata, 32'h0000_0013);
            checkOutput("reset_d_ack", {31'd0, dAck}, 32'd0);
        end
        checkOutput("reset_d_rdata", dRdata, 32'h0);
        ifReq = 1'b0;
        rstN  = 1'b1;
        tick();

        // Masked store over a known word, then load it back
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h1122_3344, 4'hF, rd, ack, err);
        checkOutput("store_ack", {31'd0, ack}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0101, rd, ack, err);
        checkOutput("mstore_ack", {31'd0, ack}, 32'd1);
        checkOutput("mstore_err", {31'd0, err}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, rd, ack, err);
        checkOutput("mload_ack", {31'd0, ack}, 32'd1);
        checkOutput("mload_rdata", rd, 32'h11AD_33EF);
        tick();
        checkOutput("mload_ack_one_cycle", {31'd0, dAck}, 32'd0);
        checkOutput("mload_rdata_hold", dRdata, 32'h11AD_33EF);

        // Held fetch at 0x0 acks every second cycle
        applyStimulus(1'b1, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, rd, ack, err);
        ifReq  = 1'b1;
        ifAddr = 32'h0;
        repeat (LAT - 1) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("hold_ack_%0d", i), {31'd0, ifAck}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                checkOutput($sformatf("hold_rdata_%0d", i), ifRdata, 32'hCAFE_0001);
            end
        end
        ifReq = 1'b0;
        repeat (LAT + 1) tick();
        checkOutput("idle_if_ack", {31'd0, ifAck}, 32'd0);
        checkOutput("idle_if_rdata", ifRdata, 32'h0000_0013);

        // Same-cycle store and fetch of 0x80: fetch sees the old word
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h0102_0304, 4'hF, rd, ack, err);
        repeat (LAT + 1) tick();
        ifReq  = 1'b1;
        ifAddr = 32'h80;
        dReq   = 1'b1;
        dSel   = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h80;
        dWdata = 32'hA5A5_A5A5;
        dBe    = 4'hF;
        tick();
        ifReq = 1'b0;
        dReq  = 1'b0;
        dSel  = 1'b0;
        dWe   = 1'b0;
        repeat (LAT - 1) tick();
        checkOutput("coll_if_ack", {31'd0, ifAck}, 32'd1);
        checkOutput("coll_if_rdata", ifRdata, 32'h0102_0304);
        checkOutput("coll_d_ack", {31'd0, dAck}, 32'd1);
        fetchOnce(32'h80, rd, ack, err);
        checkOutput("coll_next_if_ack", {31'd0, ack}, 32'd1);
        checkOutput("coll_next_if_rdata", rd, 32'hA5A5_A5A5);

        // Empty byte mask still acks but writes nothing
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h0, 4'h0, rd, ack, err);
        checkOutput("be0_ack", {31'd0, ack}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, rd, ack, err);
        checkOutput("be0_rdata", rd, 32'hA5A5_A5A5);

        // Out-of-range load and misaligned store
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, 32'h0, 4'h0, rd, ack, err);
        checkOutput("oor_load_ack", {31'd0, ack}, 32'd1);
        checkOutput("oor_load_err", {31'd0, err}, 32'd1);
        checkOutput("oor_load_rdata", rd, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        checkOutput("mis_store_ack", {31'd0, ack}, 32'd1);
        checkOutput("mis_store_err", {31'd0, err}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, rd, ack, err);
        checkOutput("mis_store_unchanged", rd, 32'hCAFE_0001);
        checkOutput("ok_load_err", {31'd0, err}, 32'd0);

        // Out-of-range fetch
        fetchOnce(32'h0001_0000, rd, ack, err);
        checkOutput("oor_fetch_ack", {31'd0, ack}, 32'd1);
        checkOutput("oor_fetch_err", {31'd0, err}, 32'd1);

        // Deselected store: no ack and no write
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, rd, ack, err);
        checkOutput("nosel_ack", {31'd0, ack}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, rd, ack, err);
        checkOutput("nosel_unchanged", rd, 32'h11AD_33EF);

        // Store presented during reset is dropped, ack suppressed
        rstN   = 1'b0;
        dReq   = 1'b1;
        dSel   = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h40;
        dWdata = 32'h0;
        dBe    = 4'hF;
        tick();
        checkOutput("rst_store_ack", {31'd0, dAck}, 32'd0);
        checkOutput("rst_store_rdata", dRdata, 32'h0);
        dReq = 1'b0;
        dSel = 1'b0;
        dWe  = 1'b0;
        rstN = 1'b1;
        tick();
        checkOutput("rst_store_ack_after", {31'd0, dAck}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, rd, ack, err);
        checkOutput("rst_store_unchanged", rd, 32'h11AD_33EF);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dual_port_bank_mem.md
# dual_port_bank_mem

Parametrised dual-port, byte-banked on-chip memory for the RV MCU. It serves the fetch stage on a read-only instruction port and the execute stage on a read/write data port. Width, depth and NOP pattern are set by parameters, and any byte-enable mask is accepted. It adds range checking with an error response and an optional registered output stage. It sits between the IF/EXE bus structs and the writeback/IF return paths.

## Interface
- DATA_W, 32, word width in bits; multiple of 8; NB = DATA_W/8 byte banks
- DEPTH, 4096, words per bank; power of two; AW = $clog2(DEPTH)
- BYTE_OFS, $clog2(DATA_W/8), low address bits dropped to form the word index
- INSTR_NOP, 32'h0000_0013, value driven on if_rdata when idle or in reset
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset; synchronous and active-low (polarity and synchronicity fixed)
- if_req  in  1  instruction fetch request
- if_addr  in  32  byte address of the fetch
- if_rdata  out  DATA_W  fetched word
- if_ack  out  1  fetch response valid
- if_err  out  1  fetch address out of range (valid with if_ack)
- d_req  in  1  data request
- d_sel  in  1  data-bus decode select for this memory
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_wdata  in  DATA_W  store data
- d_be  in  NB  byte enables; any combination is legal
- d_rdata  out  DATA_W  load data
- d_ack  out  1  data response valid
- d_err  out  1  data address out of range (valid with d_ack)

## Operation
- Word index = addr[BYTE_OFS+AW-1:BYTE_OFS]. Range error when addr[31:BYTE_OFS+AW] != 0 or addr[BYTE_OFS-1:0] != 0.
- Store (d_req & d_sel & d_we): bank b is written with d_wdata[8b+7:8b] where d_be[b]=1. d_be=0 writes nothing but still acks. A store with a range error writes nothing; it acks with d_err=1.
- Load (d_req & d_sel & !d_we): d_rdata = concatenation of all banks at the index, bank NB-1 in the MSB. A load with a range error returns 0 with d_err=1.
- Instruction port handshake: on if_req & !if_ack, the word is captured and if_ack is raised. If if_req is still high the next cycle, if_ack drops, so a held request acks every second cycle. When if_req is low, if_ack=0 and if_rdata=INSTR_NOP.
- Collision: if a data store and a fetch hit the same word in the same cycle, the fetch returns the pre-write data (read-before-write). A load in the cycle after a store to the same word returns the new data.
- There is no arbitration; both ports operate every cycle.

## Timing
- Reset (rst_n=0 at posedge): if_ack=0, if_err=0, if_rdata=INSTR_NOP, d_ack=0, d_err=0, d_rdata=0. Memory contents are untouched.
- Reset asserted mid-transaction: the pending ack is dropped. A store presented in that same cycle is not written.
- Base latency is 1 cycle: the request is sampled at edge N, and ack/rdata/err are valid after edge N, for exactly one cycle.
- Back-to-back data requests give one response per cycle. d_rdata holds its last value when d_ack=0.
- d_req with d_sel=0 produces no ack and no write.

## Configuration
- MEM_OUT_REG_EN defined: an extra register stage is added on both ports' rdata/ack/err, so latency is 2 cycles. The fetch toggle handshake is evaluated against the internal stage-1 ack. Read-before-write collision semantics are unchanged. Reset also clears the second stage, with the same reset values.
- MEM_OUT_REG_EN undefined: latency is 1 cycle as specified above.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with if_req=1 -> if_ack=0, if_rdata=32'h0000_0013, d_ack=0 throughout.
- Store of 32'hDEADBEEF with d_be=4'b0101 at 0x40 over prior 0x11223344, then load 0x40 -> d_rdata=32'h11AD33EF, d_ack high 1 cycle after each request.
- Fetch held high for 6 cycles at 0x0 -> if_ack pattern 1,0,1,0,1,0 with if_rdata = mem[0] on ack cycles.
- Same-cycle store 32'hA5A5A5A5 (d_be=4'hF) to 0x80 and fetch of 0x80 -> fetch returns the old word; a fetch the next cycle returns 32'hA5A5A5A5.
- Load at 0x0000_4000 (DEPTH=4096) and store at 0x2 -> d_ack=1, d_err=1, d_rdata=0, memory unchanged.
- With MEM_OUT_REG_EN: repeat the masked-store/load scenario -> identical data, with ack 2 cycles after the request.
